// File: rtl/canny_nms_stream.sv
`default_nettype none
// ============================================================================
// Module   : canny_nms_stream
// Brief    : Canny non-maximum suppression over a raster gradient stream,
//            3x3 window built from two internal line buffers.
// Revision : 1.0
// ============================================================================
module canny_nms_stream #(
  parameter int MAG_W    = 10,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int TIE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_s,
  input  logic             grandient_vs,
  input  logic             grandient_hs,
  input  logic             grandient_de,
  input  logic [MAG_W+5:0] gra_path,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [1:0]       max_g,
  output logic [MAG_W-1:0] nms_mag,
  output logic             line_len_err
);

  localparam int c_DATA_W = MAG_W + 6;
  localparam int c_COL_W  = $clog2(IMG_W);
  localparam int c_ROW_W  = $clog2(IMG_H);
  localparam int c_CNT_W  = $clog2(IMG_W + 2);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
  localparam logic [c_CNT_W-1:0] c_LINE_LEN = c_CNT_W'(IMG_W);
  localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
  localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [2:0]             r_vs_pipe, r_hs_pipe, r_de_pipe;
  logic                   r_vs_prev, r_hs_prev, r_armed;
  logic [c_COL_W-1:0]     r_col;
  logic [c_ROW_W-1:0]     r_row;
  logic [c_CNT_W-1:0]     r_beats;
  logic                   r_err;
  logic                   w_vs_rise, w_hs_fall, w_valid;
  logic [c_COL_W-1:0]     w_col;
  logic [c_ROW_W-1:0]     w_row;

  logic [c_DATA_W-1:0]    r_lb1 [IMG_W];
  logic [MAG_W-1:0]       r_lb2 [IMG_W];
  logic [MAG_W-1:0]       r_col_top, r_col_bot;
  logic [c_DATA_W-1:0]    r_col_mid;
  logic                   r_col_valid;

  logic [MAG_W-1:0]       r_top [3];
  logic [MAG_W-1:0]       r_mid [3];
  logic [MAG_W-1:0]       r_bot [3];
  logic [5:0]             r_meta [2];
  logic                   r_win_valid;

  logic [MAG_W-1:0]       w_first, w_second;
  logic                   w_dir_ok, w_beat_first, w_keep;
  logic [1:0]             r_max_g;
  logic [MAG_W-1:0]       r_nms_mag;

  // A vsync rising edge coinciding with de makes that beat (0,0).
  assign w_vs_rise = grandient_vs & ~r_vs_prev;
  assign w_hs_fall = ~grandient_hs & r_hs_prev;
  assign w_col     = w_vs_rise ? '0 : r_col;
  assign w_row     = w_vs_rise ? '0 : r_row;
  assign w_valid   = (r_armed | w_vs_rise) && (w_row >= c_ROW_W'(2)) && (w_col >= c_COL_W'(2));

  always_ff @(posedge clk) begin
    if (!rst_s) begin
      r_vs_pipe <= '0;
      r_hs_pipe <= '0;
      r_de_pipe <= '0;
    end else begin
      r_vs_pipe <= {r_vs_pipe[1:0], grandient_vs};
      r_hs_pipe <= {r_hs_pipe[1:0], grandient_hs};
      r_de_pipe <= {r_de_pipe[1:0], grandient_de};
    end
  end

  // Previous vsync resets high so a frame already in flight is not mistaken for a new one.
  always_ff @(posedge clk) begin
    if (!rst_s) begin
      r_vs_prev <= 1'b1;
      r_hs_prev <= 1'b0;
      r_armed   <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
    end else begin
      r_vs_prev <= grandient_vs;
      r_hs_prev <= grandient_hs;
      if (w_vs_rise) r_armed <= 1'b1;
      if (grandient_de) begin
        if (w_col == c_COL_LAST) begin
          r_col <= '0;
          r_row <= (w_row == c_ROW_LAST) ? w_row : w_row + c_ROW_ONE;
        end else begin
          r_col <= w_col + c_COL_ONE;
          r_row <= w_row;
        end
      end else if (w_vs_rise) begin
        r_col <= '0;
        r_row <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_s) begin
      r_beats <= '0;
      r_err   <= 1'b0;
    end else if (w_vs_rise) begin
      r_beats <= grandient_de ? c_CNT_ONE : '0;
      r_err   <= 1'b0;
    end else if (w_hs_fall) begin
      if (r_beats != c_LINE_LEN) r_err <= 1'b1;
      r_beats <= '0;
    end else if (grandient_de && (r_beats != '1)) begin
      r_beats <= r_beats + c_CNT_ONE;
    end
  end

  // Line buffers: only the row above needs class/dir, the row two above needs magnitude only.
  always_ff @(posedge clk) begin
    if (rst_s && grandient_de) begin
      r_lb1[w_col] <= gra_path;
      r_lb2[w_col] <= r_lb1[w_col][MAG_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_s) begin
      r_col_top   <= '0;
      r_col_mid   <= '0;
      r_col_bot   <= '0;
      r_col_valid <= 1'b0;
    end else if (grandient_de) begin
      r_col_top   <= r_lb2[w_col];
      r_col_mid   <= r_lb1[w_col];
      r_col_bot   <= gra_path[MAG_W-1:0];
      r_col_valid <= w_valid;
    end
  end

  // Index 0 is the newest column (c), index 1 the centre (c-1), index 2 is c-2.
  always_ff @(posedge clk) begin
    if (!rst_s) begin
      for (int i = 0; i < 3; i++) begin
        r_top[i] <= '0;
        r_mid[i] <= '0;
        r_bot[i] <= '0;
      end
      r_meta[0]   <= '0;
      r_meta[1]   <= '0;
      r_win_valid <= 1'b0;
    end else if (r_de_pipe[0]) begin
      r_top[0]    <= r_col_top;
      r_top[1]    <= r_top[0];
      r_top[2]    <= r_top[1];
      r_mid[0]    <= r_col_mid[MAG_W-1:0];
      r_mid[1]    <= r_mid[0];
      r_mid[2]    <= r_mid[1];
      r_bot[0]    <= r_col_bot;
      r_bot[1]    <= r_bot[0];
      r_bot[2]    <= r_bot[1];
      r_meta[0]   <= r_col_mid[c_DATA_W-1:MAG_W];
      r_meta[1]   <= r_meta[0];
      r_win_valid <= r_col_valid;
    end
  end

  always_comb begin
    w_first  = '0;
    w_second = '0;
    w_dir_ok = 1'b1;
    case (r_meta[1][3:0])
      4'b0001: begin w_first = r_mid[2]; w_second = r_mid[0]; end
      4'b0010: begin w_first = r_top[0]; w_second = r_bot[2]; end
      4'b0100: begin w_first = r_top[1]; w_second = r_bot[1]; end
      4'b1000: begin w_first = r_top[2]; w_second = r_bot[0]; end
      default: w_dir_ok = 1'b0;
    endcase
  end

  assign w_beat_first = (TIE_MODE != 0) ? (r_mid[1] >= w_first) : (r_mid[1] > w_first);
  assign w_keep       = r_win_valid & w_dir_ok & w_beat_first & (r_mid[1] > w_second);

  always_ff @(posedge clk) begin
    if (!rst_s) begin
      r_max_g   <= '0;
      r_nms_mag <= '0;
    end else if (r_de_pipe[1]) begin
      r_max_g   <= w_keep ? r_meta[1][5:4] : 2'b00;
      r_nms_mag <= w_keep ? r_mid[1] : '0;
    end
  end

  assign post_frame_vsync = r_vs_pipe[2];
  assign post_frame_href  = r_hs_pipe[2];
  assign post_frame_clken = r_de_pipe[2];
  assign max_g            = r_max_g;
  assign nms_mag          = r_nms_mag;
  assign line_len_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_canny_nms_stream.sv
`default_nettype none
// Directed bench: a strict and an asymmetric tie-break instance share one
// stimulus stream; outputs are queued per clken beat and checked against hand values.
module tb_canny_nms_stream;
  localparam int MAG_W  = 10;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int DATA_W = MAG_W + 6;
  localparam int NBEAT  = IMG_W * IMG_H;
  localparam int TGT    = 4 * IMG_W + 4;

  typedef struct {
    logic [MAG_W-1:0] ctr;
    logic [MAG_W-1:0] nb_a;
    logic [MAG_W-1:0] nb_b;
    logic [3:0]       dir;
    logic [1:0]       cls;
    logic [MAG_W+1:0] exp0;
    logic [MAG_W+1:0] exp1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_s = 1'b0;
  logic vs = 1'b0, hs = 1'b0, de = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic pv0, ph0, pc0, e0, pv1, ph1, pc1, e1;
  logic [1:0] g0, g1;
  logic [MAG_W-1:0] m0, m1;
  logic [31:0] all_out;

  logic [DATA_W-1:0] img [IMG_H][IMG_W];
  logic [MAG_W+1:0] q0[$];
  logic [MAG_W+1:0] q1[$];
  logic [2:0] hist [3];
  int checks = 0, failures = 0, sync_bad = 0, sync_skip = 4;
  vec_t vt [10];

  always #5 clk = ~clk;

  canny_nms_stream #(.MAG_W(MAG_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .TIE_MODE(0)) u_strict (
    .clk(clk), .rst_s(rst_s), .grandient_vs(vs), .grandient_hs(hs), .grandient_de(de),
    .gra_path(din), .post_frame_vsync(pv0), .post_frame_href(ph0), .post_frame_clken(pc0),
    .max_g(g0), .nms_mag(m0), .line_len_err(e0));

  canny_nms_stream #(.MAG_W(MAG_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .TIE_MODE(1)) u_tie (
    .clk(clk), .rst_s(rst_s), .grandient_vs(vs), .grandient_hs(hs), .grandient_de(de),
    .gra_path(din), .post_frame_vsync(pv1), .post_frame_href(ph1), .post_frame_clken(pc1),
    .max_g(g1), .nms_mag(m1), .line_len_err(e1));

  assign all_out = {pv0, ph0, pc0, g0, m0, e0, pv1, ph1, pc1, g1, m1, e1};

  // Sync outputs must equal the inputs sampled three cycles earlier.
  always @(negedge clk) begin
    if (!rst_s) begin
      sync_skip <= 4;
    end else begin
      if (sync_skip > 0) sync_skip <= sync_skip - 1;
      else if (({pv0, ph0, pc0} !== hist[2]) || ({pv1, ph1, pc1} !== hist[2]))
        sync_bad <= sync_bad + 1;
      if (pc0) q0.push_back({g0, m0});
      if (pc1) q1.push_back({g1, m1});
    end
    hist[2] <= hist[1];
    hist[1] <= hist[0];
    hist[0] <= {vs, hs, de};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q0.delete();
    q1.delete();
  endtask

  task automatic drive_frame(input int gap_max, input int short_row, input int nrows);
    vs = 1'b1; hs = 1'b0; de = 1'b0;
    tick(); tick();
    for (int r = 0; r < nrows; r++) begin
      hs = 1'b1;
      for (int c = 0; c < ((r == short_row) ? IMG_W - 1 : IMG_W); c++) begin
        if (gap_max > 0) begin
          repeat ($urandom_range(0, gap_max)) begin
            de = 1'b0;
            tick();
          end
        end
        de = 1'b1;
        din = img[r][c];
        tick();
      end
      de = 1'b0; hs = 1'b0; din = '0;
      if (r == short_row) begin
        @(negedge clk);
        chk("err_before_hs_fall", {e0, e1}, 2'b00);
        tick();
        @(negedge clk);
        chk("err_after_short_line", {e0, e1}, 2'b11);
        tick();
      end else begin
        tick(); tick();
      end
    end
    if (nrows == IMG_H) begin
      vs = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic set_ridge();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = {2'b10, 4'b0100, (r == 3) ? 10'd50 : 10'd10};
  endtask

  function automatic logic [MAG_W+1:0] ridge_exp(input int k);
    return ((k / IMG_W == 4) && (k % IMG_W >= 2)) ? {2'd2, 10'd50} : '0;
  endfunction

  task automatic check_ridge(input string name);
    chk({name, " beats_strict"}, q0.size(), NBEAT);
    chk({name, " beats_tie"}, q1.size(), NBEAT);
    for (int k = 0; k < NBEAT; k++) begin
      if (k < q0.size()) chk($sformatf("%s strict k=%0d", name, k), q0[k], ridge_exp(k));
      if (k < q1.size()) chk($sformatf("%s tie k=%0d", name, k), q1[k], ridge_exp(k));
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = '0;
    img[3][3] = {v.cls, v.dir, v.ctr};
    case (v.dir)
      4'b0010: begin img[2][4] = {6'd0, v.nb_a}; img[4][2] = {6'd0, v.nb_b}; end
      4'b0100: begin img[2][3] = {6'd0, v.nb_a}; img[4][3] = {6'd0, v.nb_b}; end
      4'b1000: begin img[2][2] = {6'd0, v.nb_a}; img[4][4] = {6'd0, v.nb_b}; end
      default: begin img[3][2] = {6'd0, v.nb_a}; img[3][4] = {6'd0, v.nb_b}; end
    endcase
  endtask

  initial begin
    vt[0] = '{10'd30,   10'd30,   10'd20,   4'b0001, 2'd3, 12'h000, {2'd3, 10'd30}};
    vt[1] = '{10'd30,   10'd20,   10'd30,   4'b0001, 2'd3, 12'h000, 12'h000};
    vt[2] = '{10'd40,   10'd39,   10'd39,   4'b0010, 2'd1, {2'd1, 10'd40}, {2'd1, 10'd40}};
    vt[3] = '{10'd40,   10'd40,   10'd10,   4'b0100, 2'd2, 12'h000, {2'd2, 10'd40}};
    vt[4] = '{10'd5,    10'd6,    10'd0,    4'b1000, 2'd1, 12'h000, 12'h000};
    vt[5] = '{10'd1023, 10'd1022, 10'd1022, 4'b1000, 2'd3, {2'd3, 10'd1023}, {2'd3, 10'd1023}};
    vt[6] = '{10'd100,  10'd0,    10'd0,    4'b0000, 2'd2, 12'h000, 12'h000};
    vt[7] = '{10'd100,  10'd0,    10'd0,    4'b0011, 2'd2, 12'h000, 12'h000};
    vt[8] = '{10'd0,    10'd0,    10'd0,    4'b0100, 2'd1, 12'h000, 12'h000};
    vt[9] = '{10'd100,  10'd99,   10'd100,  4'b0100, 2'd1, 12'h000, 12'h000};

    // Power-up reset
    rst_s = 1'b0;
    tick();
    @(negedge clk);
    chk("reset_outputs", all_out, 32'h0);
    tick();
    rst_s = 1'b1;
    tick();

    // Horizontal ridge, gapless then with random de gaps
    set_ridge();
    clear_q();
    drive_frame(0, -1, IMG_H);
    check_ridge("ridge_gapless");
    clear_q();
    drive_frame(3, -1, IMG_H);
    check_ridge("ridge_gaps");

    // Neighbour / tie / direction vectors, target centre (3,3) seen at input beat (4,4)
    for (int i = 0; i < 10; i++) begin
      load_vec(vt[i]);
      clear_q();
      drive_frame(0, -1, IMG_H);
      chk($sformatf("vec%0d beats", i), q0.size(), NBEAT);
      if (q0.size() > TGT) chk($sformatf("vec%0d strict", i), q0[TGT], vt[i].exp0);
      if (q1.size() > TGT) chk($sformatf("vec%0d tie", i), q1[TGT], vt[i].exp1);
    end

    // Short line sets the sticky error until the next vsync rising edge
    set_ridge();
    clear_q();
    drive_frame(0, 2, IMG_H);
    chk("short_frame_beats", q0.size(), NBEAT - 1);
    chk("err_held_after_frame", {e0, e1}, 2'b11);
    vs = 1'b1;
    @(negedge clk);
    chk("err_until_vs_rise", {e0, e1}, 2'b11);
    tick();
    @(negedge clk);
    chk("err_cleared_by_vs", {e0, e1}, 2'b00);

    // Mid-frame reset: short last line leaves err and a kept pixel held
    clear_q();
    drive_frame(0, 4, 5);
    @(negedge clk);
    chk("held_before_reset", {g0, m0, g1, m1, e0, e1}, {2'd2, 10'd50, 2'd2, 10'd50, 2'b11});
    rst_s = 1'b0;
    tick();
    @(negedge clk);
    chk("midframe_reset_outputs", all_out, 32'h0);
    repeat (3) tick();
    rst_s = 1'b1;
    clear_q();
    hs = 1'b1;
    for (int c = 0; c < IMG_W; c++) begin
      de = 1'b1;
      din = {2'b11, 4'b0001, 10'd500};
      tick();
    end
    de = 1'b0; hs = 1'b0; din = '0;
    repeat (5) tick();
    chk("unarmed_beats", q0.size(), IMG_W);
    for (int k = 0; k < IMG_W; k++) begin
      if (k < q0.size()) chk($sformatf("unarmed strict k=%0d", k), q0[k], 12'h000);
      if (k < q1.size()) chk($sformatf("unarmed tie k=%0d", k), q1[k], 12'h000);
    end
    vs = 1'b0;
    repeat (3) tick();

    // Counters restart on the next vsync
    clear_q();
    drive_frame(2, -1, IMG_H);
    check_ridge("ridge_after_reset");
    chk("err_final", {e0, e1}, 2'b00);
    chk("sync_delay_mismatches", sync_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
